// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, pipeline depth and sync-flag types for the
// scanout, the renderer and the bench.
package vga_timing_pkg;

  localparam int unsigned CntWidth  = 10;
  localparam int unsigned RgbWidth  = 12;
  // idx -> line-buffer RAM -> palette RAM -> pin register
  localparam int unsigned PipeDepth = 3;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
  } vga_timing_t;

  localparam vga_timing_t DefaultTiming = '{
    h_active: 640,
    h_front:  16,
    h_sync:   96,
    h_back:   48,
    v_active: 480,
    v_front:  10,
    v_sync:   2,
    v_back:   33
  };

  // Sync levels are active-low, so the idle pattern keeps both syncs high.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_flags_t;

  localparam sync_flags_t FlagsIdle = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

  function automatic int unsigned h_total(vga_timing_t t);
    return t.h_active + t.h_front + t.h_sync + t.h_back;
  endfunction

  function automatic int unsigned v_total(vga_timing_t t);
    return t.v_active + t.v_front + t.v_sync + t.v_back;
  endfunction

  // Half-open window test [lo, hi) on a counter value.
  function automatic logic in_range(logic [CntWidth-1:0] cnt, int unsigned lo,
                                    int unsigned hi);
    return (32'(cnt) >= lo) && (32'(cnt) < hi);
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Scanout-side bundle: frame/line pulses, line-buffer read port and the VGA pins.
interface vga_scanout_if;

  logic                                  start_of_screen;
  logic                                  start_of_line;
  logic                                  vblank_irq;
  logic [vga_timing_pkg::CntWidth-1:0]   linebuf_idx;
  logic [vga_timing_pkg::RgbWidth-1:0]   linebuf_rgb_data;
  logic [3:0]                            vga_r;
  logic [3:0]                            vga_g;
  logic [3:0]                            vga_b;
  logic                                  vga_hsync;
  logic                                  vga_vsync;
  logic [vga_timing_pkg::CntWidth-1:0]   line_number;

  modport master (
    output start_of_screen,
    output start_of_line,
    output vblank_irq,
    output linebuf_idx,
    input  linebuf_rgb_data,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hsync,
    output vga_vsync,
    output line_number
  );

  modport slave (
    input  start_of_screen,
    input  start_of_line,
    input  vblank_irq,
    input  linebuf_idx,
    output linebuf_rgb_data,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hsync,
    input  vga_vsync,
    input  line_number
  );

endinterface

// File: rtl/sync_delay.sv
// N-stage shift register that carries {active, hsync, vsync} alongside the
// memory read pipeline; resets to the idle pattern.
module sync_delay
  import vga_timing_pkg::*;
#(
  parameter int unsigned Depth = PipeDepth
) (
  input  logic        clk,
  input  logic        reset,
  input  sync_flags_t i_flags,
  output sync_flags_t o_flags
);

  sync_flags_t r_stage [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_stage[i] <= FlagsIdle;
      end
    end else begin
      r_stage[0] <= i_flags;
      for (int i = 1; i < int'(Depth); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_flags = r_stage[Depth-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing: h/v counters, line-buffer index, frame/line pulses and the
// registered pin stage, 3 clocks behind the counters.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter vga_timing_t Timing = DefaultTiming
) (
  input logic           clk,
  input logic           reset,
  vga_scanout_if.master bus
);

  typedef logic [CntWidth-1:0] cnt_t;

  localparam int unsigned HTotal     = h_total(Timing);
  localparam int unsigned VTotal     = v_total(Timing);
  localparam int unsigned HSyncStart = Timing.h_active + Timing.h_front;
  localparam int unsigned VSyncStart = Timing.v_active + Timing.v_front;

  localparam cnt_t HLast       = cnt_t'(HTotal - 1);
  localparam cnt_t VLast       = cnt_t'(VTotal - 1);
  localparam cnt_t VPreScreen  = cnt_t'(VTotal - 2);
  localparam cnt_t VActiveLast = cnt_t'(Timing.v_active - 1);
  localparam cnt_t VBlankStart = cnt_t'(Timing.v_active);

  cnt_t                r_hcnt;
  cnt_t                r_vcnt;
  cnt_t                w_hcnt_d;
  cnt_t                w_vcnt_d;
  logic                w_h_wrap;
  logic                w_v_wrap;
  logic                w_line_end;
  sync_flags_t         w_flags;
  sync_flags_t         w_flags_dly;
  logic [RgbWidth-1:0] r_rgb;
  logic                r_hsync;
  logic                r_vsync;

  // Wrap on >= so any out-of-range value falls back to 0 at the next wrap.
  always_comb begin
    w_h_wrap = (r_hcnt >= HLast);
    w_v_wrap = (r_vcnt >= VLast);
    w_hcnt_d = w_h_wrap ? '0 : r_hcnt + cnt_t'(1);
    w_vcnt_d = r_vcnt;
    if (w_h_wrap) begin
      w_vcnt_d = w_v_wrap ? '0 : r_vcnt + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_hcnt_d;
      r_vcnt <= w_vcnt_d;
    end
  end

  // Stage 0: decode straight from the counters.
  always_comb begin
    w_flags        = FlagsIdle;
    w_flags.active = in_range(r_hcnt, 0, Timing.h_active) &&
                     in_range(r_vcnt, 0, Timing.v_active);
    w_flags.hsync  = !in_range(r_hcnt, HSyncStart, HSyncStart + Timing.h_sync);
    w_flags.vsync  = !in_range(r_vcnt, VSyncStart, VSyncStart + Timing.v_sync);
  end

  assign bus.linebuf_idx = w_flags.active ? r_hcnt : '0;
  assign bus.line_number = r_vcnt;

  // Line pulses fire one line early so the renderer can fill the back buffer.
  always_comb begin
    w_line_end          = (r_hcnt == HLast);
    bus.start_of_line   = w_line_end && ((r_vcnt == VLast) || (r_vcnt < VActiveLast));
    bus.start_of_screen = w_line_end && (r_vcnt == VPreScreen);
    bus.vblank_irq      = (r_hcnt == '0) && (r_vcnt == VBlankStart);
  end

  // Two flag stages cover the two RAM reads; the pin register is the third.
  sync_delay #(
    .Depth (PipeDepth - 1)
  ) u_sync_delay (
    .clk     (clk),
    .reset   (reset),
    .i_flags (w_flags),
    .o_flags (w_flags_dly)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb   <= '0;
      r_hsync <= FlagsIdle.hsync;
      r_vsync <= FlagsIdle.vsync;
    end else begin
      r_rgb   <= w_flags_dly.active ? bus.linebuf_rgb_data : '0;
      r_hsync <= w_flags_dly.hsync;
      r_vsync <= w_flags_dly.vsync;
    end
  end

  assign bus.vga_r     = r_rgb[11:8];
  assign bus.vga_g     = r_rgb[7:4];
  assign bus.vga_b     = r_rgb[3:0];
  assign bus.vga_hsync = r_hsync;
  assign bus.vga_vsync = r_vsync;

endmodule
